// File: rtl/memoria_pkg.sv
// memoria_pkg
//   Shared definitions for the bus-attached memory slice:
//   - default geometry and read latency for memoria_bus_param
//   - FSM state type and its fixed encoding
//   - counter width able to hold any legal read latency (0..7)
package memoria_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned RD_LAT_DEF = 2;

    // Width of the read-latency counter
    localparam int unsigned CNT_W = 3;

    // FSM encoding (kept as explicit constants for compatibility with
    // existing waveform decoders and the original state values)
    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t WRITE     = 3'd1;
    localparam state_t READ_WAIT = 3'd2;
    localparam state_t ACK_HOLD  = 3'd3;
    localparam state_t TURN      = 3'd4;

endpackage

// File: rtl/memoria_array.sv
// memoria_array
//   Register file of 2**ADDR_W words of DATA_W bits.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low clear of every word
//     we, waddr, wdata  synchronous write port
//     raddr_a, rdata_a  asynchronous read port A
//     raddr_b, rdata_b  asynchronous read port B
module memoria_array
    import memoria_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/memoria_bus_param.sv
// memoria_bus_param
//   Memory slave on a four-phase REQ/ACK handshake with a shared
//   bidirectional data bus and a programmable read latency.
//   Ports:
//     CLK, RST_N      clock, asynchronous active-low reset
//     REQ             master request (four-phase)
//     WR              1 = read, 0 = write; sampled with REQ in IDLE
//     ADDR            word address; sampled with REQ in IDLE
//     dataBus         write data in; read data out during read ACK_HOLD only
//     ACK             transfer complete, held until REQ falls
//     almacenamiento  combinational mem[ADDR] at the live ADDR
//     entrada         last write data stored
//     salida          last read data delivered
module memoria_bus_param
    import memoria_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WR,
    input  logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic              ACK,
    output logic [DATA_W-1:0] almacenamiento,
    output logic [DATA_W-1:0] entrada,
    output logic [DATA_W-1:0] salida
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_q;
    logic              wr_q;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;
    logic              bus_drive;

    // The array write happens on the edge that leaves WRITE, so a reset
    // landing while in WRITE drops the pending write.
    assign mem_we = (state == WRITE);

    memoria_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (CLK),
        .rst_n   (RST_N),
        .we      (mem_we),
        .waddr   (addr_q),
        .wdata   (data_q),
        .raddr_a (addr_q),
        .rdata_a (mem_rd),
        .raddr_b (ADDR),
        .rdata_b (almacenamiento)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            entrada <= '0;
            salida  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ) begin
                        addr_q <= ADDR;
                        wr_q   <= WR;
                        if (WR) begin
                            cnt   <= CNT_W'(RD_LAT);
                            state <= READ_WAIT;
                        end else begin
                            data_q <= dataBus;
                            state  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Completes regardless of REQ once entered
                    entrada <= data_q;
                    state   <= ACK_HOLD;
                end
                READ_WAIT: begin
                    // Abort takes priority over completion
                    if (!REQ) begin
                        cnt   <= '0;
                        state <= TURN;
                    end else if (cnt == '0) begin
                        rd_q   <= mem_rd;
                        salida <= mem_rd;
                        state  <= ACK_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK_HOLD: begin
                    if (!REQ) begin
                        state <= TURN;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ACK       = (state == ACK_HOLD);
    assign bus_drive = ACK && wr_q;
    assign dataBus   = bus_drive ? rd_q : 'z;

endmodule

// File: doc/memoria_bus_param.md
MEMORIA_BUS_PARAM -- requirements
Module: memoria_bus_param

Interface
REQ-001 Parameter DATA_W, default 4: width of a data word and of dataBus.
REQ-002 Parameter ADDR_W, default 2: address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 2, legal range 0..7: wait cycles between capturing a read and driving its data.
REQ-004 CLK  input  1: single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1: asynchronous, active-low reset.
REQ-006 REQ  input  1: master request, four-phase handshake.
REQ-007 WR  input  1: 1 = read, 0 = write; sampled with REQ.
REQ-008 ADDR  input  ADDR_W: word address; sampled with REQ.
REQ-009 dataBus  inout  DATA_W: write data in; read data out only while this block drives it.
REQ-010 ACK  output  1: transfer complete; held high until REQ falls.
REQ-011 almacenamiento  output  DATA_W: combinational content of mem[ADDR] at the live ADDR.
REQ-012 entrada  output  DATA_W: last write data captured.
REQ-013 salida  output  DATA_W: last read data delivered.

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, READ_WAIT, ACK_HOLD and TURN.
REQ-015 IDLE: ACK=0 and dataBus released (Z); on REQ=1, capture WR, ADDR and (if WR=0) dataBus into addr_q/data_q/wr_q.
REQ-016 From IDLE, WR=0 SHALL go to WRITE; WR=1 SHALL go to READ_WAIT with the latency counter loaded to RD_LAT.
REQ-017 WRITE: mem[addr_q]<=data_q and entrada<=data_q on that edge; next state ACK_HOLD.
REQ-018 READ_WAIT: decrement the counter each cycle; at 0, load rd_q<=mem[addr_q] and salida<=mem[addr_q], then go to ACK_HOLD.
REQ-019 RD_LAT=0 SHALL give ACK on the second edge after REQ is sampled.
REQ-020 ACK_HOLD: ACK=1; on a read, dataBus=rd_q; stay while REQ=1; on REQ=0, go to TURN.
REQ-021 TURN: ACK=0 and dataBus Z for exactly one cycle, then IDLE.
REQ-022 In TURN, REQ=1 SHALL be ignored; it is accepted in IDLE on the following edge.
REQ-023 REQ falling during READ_WAIT SHALL abort the read: go to TURN with no drive, no ACK and salida unchanged.
REQ-024 Once WRITE is entered, a write SHALL complete even if REQ falls.
REQ-025 dataBus SHALL be driven only in ACK_HOLD of a read; it is never driven in any other state or during reset.
REQ-026 ADDR is exactly ADDR_W bits, so every address is valid and there is no out-of-range case.
REQ-027 A read immediately after a write to the same address SHALL return the new data.
REQ-028 almacenamiento SHALL track ADDR combinationally in every state, including during reset.
REQ-029 ADDR, WR and dataBus changing while not in IDLE SHALL have no effect.

Reset
REQ-030 RST_N=0 SHALL immediately force IDLE, ACK=0, dataBus Z, counter=0, entrada=0, salida=0, and every mem word=0.
REQ-031 Reset asserted mid-transfer SHALL discard the transfer; a pending write is not performed.
REQ-032 Release of RST_N SHALL take effect on the next rising CLK edge; if REQ=1 at that edge, a new transfer starts.

Structure
REQ-033 Package memoria_pkg SHALL hold the state enum encoding and the default DATA_W, ADDR_W and RD_LAT constants.
REQ-034 Sub-module memoria_array SHALL be a register file with one synchronous write port, two asynchronous read ports (addr_q and live ADDR) and async clear.
REQ-035 The FSM, counter, tri-state control and capture registers SHALL live in memoria_bus_param.

Verification
REQ-036 Reset, then read addr 3 with RD_LAT=2 -> ACK on the 4th edge after REQ, dataBus=0, salida=0.
REQ-037 Write 4'hA to addr 1, then read addr 1 -> entrada=A; ACK held while REQ=1; dataBus=A; one TURN cycle with Z.
REQ-038 Read request, then REQ dropped after 1 cycle in READ_WAIT -> no ACK, dataBus stays Z, salida keeps its prior value.
REQ-039 RST_N pulsed low during a write's ACK_HOLD and during a read's ACK_HOLD -> bus Z and ACK 0 immediately; all words read 0; almacenamiento=0.
REQ-040 Sweep RD_LAT=0 and 7, and DATA_W=8/ADDR_W=4: write 8'h5A to addr 15, read it back -> 8'h5A after RD_LAT+2 edges; also check that the address wraps back to 0.
REQ-041 Back-to-back transfers with REQ held high through TURN -> the second transfer is captured in IDLE one cycle after TURN; there is no bus contention.
